// File: rtl/layer3_sched_pkg.sv
// Shared types and constants for the layer3 weight scheduler.
// State encoding, default weight counts and counter width helpers.
package layer3_sched_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD1 = 3'd1;
  localparam logic [2:0] S_LOAD2 = 3'd2;
  localparam logic [2:0] S_LOAD3 = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int DEF_W1_COUNT = 294912;
  localparam int DEF_W2_COUNT = 589824;
  localparam int DEF_W3_COUNT = 32768;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/layer3_weight_scheduler_counter.sv
// Load/compare word counter with terminal-count flag.
// Wraps to zero on the accept that matches the last index.
module sched_word_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = en && (count == last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/layer3_weight_scheduler.sv
// Demuxes the shared weight stream onto conv1/conv2/downsample,
// then gates exactly one frame of pixels into the basic block.
module layer3_weight_scheduler
  import layer3_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 32,
  parameter int IMAGE_HEIGHT   = 32,
  parameter int CHANNEL_NUM_IN = 128,
  parameter int W1_COUNT       = DEF_W1_COUNT,
  parameter int W2_COUNT       = DEF_W2_COUNT,
  parameter int W3_COUNT       = DEF_W3_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  w_ready,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  pxl_ready,
  output logic                  valid_weight_out1,
  output logic                  valid_weight_out2,
  output logic                  valid_weight_out3,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  busy,
  output logic                  done
);

  localparam int PIX_COUNT =
    IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN;
  localparam int WCNT_W =
    cnt_width(max3(W1_COUNT, W2_COUNT, W3_COUNT));
  localparam int PCNT_W = cnt_width(PIX_COUNT);

  logic [2:0]        state;
  logic [WCNT_W-1:0] w_last;
  logic              w_acc;
  logic              p_acc;
  logic              w_tc;
  logic              p_tc;
  logic              cnt_clear;

  assign w_ready   = (state == S_LOAD1) ||
                     (state == S_LOAD2) ||
                     (state == S_LOAD3);
  assign pxl_ready = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign w_acc     = w_valid_in && w_ready;
  assign p_acc     = valid_in && pxl_ready;
  assign cnt_clear = (state == S_IDLE);

  always_comb begin
    w_last = '0;
    unique case (state)
      S_LOAD1: w_last = WCNT_W'(W1_COUNT - 1);
      S_LOAD2: w_last = WCNT_W'(W2_COUNT - 1);
      S_LOAD3: w_last = WCNT_W'(W3_COUNT - 1);
      default: w_last = '0;
    endcase
  end

  sched_word_counter #(.WIDTH(WCNT_W)) u_wcnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (w_acc),
    .last  (w_last),
    .tc    (w_tc)
  );

  sched_word_counter #(.WIDTH(PCNT_W)) u_pcnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (p_acc),
    .last  (PCNT_W'(PIX_COUNT - 1)),
    .tc    (p_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      valid_weight_out1 <= 1'b0;
      valid_weight_out2 <= 1'b0;
      valid_weight_out3 <= 1'b0;
      weight_out        <= '0;
      valid_out         <= 1'b0;
      pxl_out           <= '0;
    end else begin
      valid_weight_out1 <= w_acc && (state == S_LOAD1);
      valid_weight_out2 <= w_acc && (state == S_LOAD2);
      valid_weight_out3 <= w_acc && (state == S_LOAD3);
      valid_out         <= p_acc;
      if (w_acc) weight_out <= w_in;
      if (p_acc) pxl_out <= pxl_in;
      unique case (state)
        S_IDLE:  if (start) state <= S_LOAD1;
        S_LOAD1: if (w_tc) state <= S_LOAD2;
        S_LOAD2: if (w_tc) state <= S_LOAD3;
        S_LOAD3: if (w_tc) state <= S_RUN;
        S_RUN:   if (p_tc) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer3_weight_scheduler.sv
// Directed bench for layer3_weight_scheduler.
// Small config: W1=4, W2=6, W3=2, frame 2x2x2.
module tb_layer3_weight_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        w_valid_in;
  logic [31:0] w_in;
  logic        w_ready;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic        pxl_ready;
  logic        vw1, vw2, vw3;
  logic [31:0] weight_out;
  logic        valid_out;
  logic [31:0] pxl_out;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int passes = 0;

  always #5 clk = ~clk;

  layer3_weight_scheduler #(
    .DATA_WIDTH     (32),
    .IMAGE_WIDTH    (2),
    .IMAGE_HEIGHT   (2),
    .CHANNEL_NUM_IN (2),
    .W1_COUNT       (4),
    .W2_COUNT       (6),
    .W3_COUNT       (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .w_valid_in        (w_valid_in),
    .w_in              (w_in),
    .w_ready           (w_ready),
    .valid_in          (valid_in),
    .pxl_in            (pxl_in),
    .pxl_ready         (pxl_ready),
    .valid_weight_out1 (vw1),
    .valid_weight_out2 (vw2),
    .valid_weight_out3 (vw3),
    .weight_out        (weight_out),
    .valid_out         (valid_out),
    .pxl_out           (pxl_out),
    .busy              (busy),
    .done              (done)
  );

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic        st;
    logic        wv;
    logic [31:0] wd;
    logic        pv;
    logic [31:0] pd;
    logic [2:0]  e_vw;
    logic [31:0] e_w;
    logic        e_vo;
    logic [31:0] e_p;
    logic [3:0]  e_fl;
  } vec_t;

  vec_t tab[22];

  function automatic vec_t mk(
    input logic st, input logic wv, input logic [31:0] wd,
    input logic pv, input logic [31:0] pd,
    input logic [2:0] vw, input logic [31:0] ew,
    input logic vo, input logic [31:0] ep,
    input logic [3:0] fl);
    vec_t v;
    v.st = st; v.wv = wv; v.wd = wd;
    v.pv = pv; v.pd = pd;
    v.e_vw = vw; v.e_w = ew;
    v.e_vo = vo; v.e_p = ep;
    v.e_fl = fl;
    return v;
  endfunction

  function automatic logic [2:0] port_of(input int k);
    if (k <= 4) return 3'b001;
    if (k <= 10) return 3'b010;
    return 3'b100;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input bit gap, input bit early,
                          input bit restart);
    int idx;
    int p;
    int cyc;
    logic [2:0] exp_vw;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("pass_busy", 32'(busy), 32'd1);
    chk("pass_first_port1_ready", 32'(w_ready), 32'd1);
    idx = 1;
    cyc = 0;
    while (idx <= 12 && cyc < 100) begin
      w_valid_in = gap ? (cyc % 2 == 0) : 1'b1;
      w_in = 32'h40 + 32'(idx);
      valid_in = early;
      pxl_in = 32'h200;
      start = restart && (idx == 6);
      tick;
      start = 1'b0;
      exp_vw = w_valid_in ? port_of(idx) : 3'b000;
      chk("ld_strobe", 32'({vw3, vw2, vw1}), 32'(exp_vw));
      if (w_valid_in) begin
        chk("ld_word", weight_out, 32'h40 + 32'(idx));
        idx++;
      end
      chk("ld_wready", 32'(w_ready), 32'(idx <= 12));
      chk("ld_pready", 32'(pxl_ready), 32'(idx > 12));
      if (early) chk("early_no_pix", 32'(valid_out), 32'd0);
      cyc++;
    end
    if (idx <= 12) chk("ld_timeout", 32'(idx), 32'd13);
    w_valid_in = 1'b0;
    p = 0;
    cyc = 0;
    while (p < 8 && cyc < 100) begin
      if (gap && !(early && p == 0))
        valid_in = 1'($urandom_range(0, 1));
      else
        valid_in = 1'b1;
      pxl_in = 32'h200 + 32'(p);
      start = restart && (p == 3);
      tick;
      start = 1'b0;
      chk("px_strobe", 32'(valid_out), 32'(valid_in));
      chk("px_wstrobe", 32'({vw3, vw2, vw1}), 32'd0);
      if (valid_in) begin
        chk("px_word", pxl_out, 32'h200 + 32'(p));
        p++;
      end
      chk("px_done", 32'(done), 32'(p == 8));
      cyc++;
    end
    if (p < 8) chk("px_timeout", 32'(p), 32'd8);
    valid_in = 1'b0;
    pxl_in = '0;
    tick;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd0);
    chk("end_vo", 32'(valid_out), 32'd0);
    passes++;
    chk("done_count", 32'(done_cnt), 32'(passes));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    w_valid_in = 1'b0;
    w_in = '0;
    valid_in = 1'b0;
    pxl_in = '0;

    tab[0] = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1010);
    for (int k = 1; k <= 12; k++)
      tab[k] = mk(0, 1, 32'(k), 0, 0, port_of(k), 32'(k), 0, 0,
                  {1'b1, 1'b0, k < 12, k == 12});
    for (int i = 1; i <= 8; i++)
      tab[12 + i] = mk(0, 0, 0, 1, 32'(100 + i), 3'b000, 32'd12,
                       1, 32'(100 + i),
                       {1'b1, i == 8, 1'b0, i < 8});
    tab[21] = mk(0, 0, 0, 0, 0, 3'b000, 32'd12, 0, 32'd108, 4'b0000);

    tick;
    tick;
    chk("rst_strobes", 32'({vw3, vw2, vw1}), 32'd0);
    chk("rst_weight", weight_out, 32'd0);
    chk("rst_pxl", pxl_out, 32'd0);
    chk("rst_vo", 32'(valid_out), 32'd0);
    chk("rst_flags", 32'({busy, done, w_ready, pxl_ready}), 32'd0);
    reset = 1'b0;
    tick;

    for (int r = 0; r < 22; r++) begin
      start = tab[r].st;
      w_valid_in = tab[r].wv;
      w_in = tab[r].wd;
      valid_in = tab[r].pv;
      pxl_in = tab[r].pd;
      tick;
      chk($sformatf("tab%0d_vw", r), 32'({vw3, vw2, vw1}),
          32'(tab[r].e_vw));
      chk($sformatf("tab%0d_w", r), weight_out, tab[r].e_w);
      chk($sformatf("tab%0d_vo", r), 32'(valid_out),
          32'(tab[r].e_vo));
      chk($sformatf("tab%0d_p", r), pxl_out, tab[r].e_p);
      chk($sformatf("tab%0d_fl", r),
          32'({busy, done, w_ready, pxl_ready}), 32'(tab[r].e_fl));
    end
    passes++;
    chk("tab_done_count", 32'(done_cnt), 32'(passes));

    run_pass(1'b1, 1'b0, 1'b0);
    run_pass(1'b0, 1'b1, 1'b1);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      w_valid_in = 1'b1;
      w_in = 32'h300 + 32'(k);
      tick;
      chk("pre_rst_strobe", 32'({vw3, vw2, vw1}), 32'(port_of(k)));
    end
    reset = 1'b1;
    w_in = 32'd99;
    tick;
    reset = 1'b0;
    w_valid_in = 1'b0;
    chk("mid_rst_strobes", 32'({vw3, vw2, vw1}), 32'd0);
    chk("mid_rst_weight", weight_out, 32'd0);
    chk("mid_rst_flags", 32'({busy, done, w_ready, pxl_ready}), 32'd0);
    tick;
    chk("post_rst_strobes", 32'({vw3, vw2, vw1}), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_pass(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
